// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges in-order WB-stage writes with queued
// mul/div results onto the single write port and tracks pending mul/div destinations.
module rf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_hold,
  input  logic        md_valid,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  output logic        md_ready,
  input  logic        iss_md,
  input  logic [4:0]  iss_waddr,
  input  logic [4:0]  qA,
  input  logic [4:0]  qB,
  output logic        raw_stall,
  output logic [4:0]  W,
  output logic [31:0] din,
  output logic        RFWr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic [4:0]       mem_addr_q [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ST_W-1:0]  starve_q, starve_d;
  logic [31:0]      pending_q, pending_d;
  logic [4:0]       w_q, w_d;
  logic [31:0]      din_q, din_d;
  logic             rfwr_q, rfwr_d;

  logic pipe_req, fifo_empty, forced, pop, grant_pipe, push;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign pipe_req   = pipe_we && (pipe_waddr != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign forced     = !fifo_empty && (starve_q == ST_W'(STARVE_MAX));
  assign pop        = !fifo_empty && (forced || !pipe_req);
  assign grant_pipe = pipe_req && !forced;
  assign md_ready   = (count_q < CNT_W'(DEPTH));
  // A zero-destination result is handshaken but never queued.
  assign push       = md_valid && md_ready && (md_waddr != 5'd0);
  assign head_addr  = mem_addr_q[rd_ptr_q];
  assign head_data  = mem_data_q[rd_ptr_q];

  assign pipe_hold  = pipe_req && forced;
  assign raw_stall  = pending_q[qA] | pending_q[qB];
  assign W          = w_q;
  assign din        = din_q;
  assign RFWr       = rfwr_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    pending_d = pending_q;
    w_d       = w_q;
    din_d     = din_q;
    rfwr_d    = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    // Non-empty and not popped means the WB stage won this cycle.
    if (pop || fifo_empty)            starve_d = '0;
    else if (!forced)                 starve_d = starve_q + ST_W'(1);

    if (pop) begin
      rfwr_d = 1'b1;
      w_d    = head_addr;
      din_d  = head_data;
      pending_d[head_addr] = 1'b0;
    end else if (grant_pipe) begin
      rfwr_d = 1'b1;
      w_d    = pipe_waddr;
      din_d  = pipe_wdata;
    end

    // Applied after the pop clear so a same-register set wins.
    if (iss_md && (iss_waddr != 5'd0)) pending_d[iss_waddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      w_q       <= '0;
      din_q     <= '0;
      rfwr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      w_q       <= w_d;
      din_q     <= din_d;
      rfwr_q    <= rfwr_d;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read when count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= md_waddr;
      mem_data_q[wr_ptr_q] <= md_wdata;
    end
  end

endmodule
